// File: rtl/exec_seq_pkg.sv
// rtl/exec_seq_pkg.sv - shared command codes, EFLAGS bit indices, size encodings and FSM states
package exec_seq_pkg;

    // Width of an operand-size bit count (holds 8, 16 or 32).
    localparam int N_W = 6;

    // Command codes from the generated command table.
    localparam int CMD_ADD  = 0;
    localparam int CMD_ADC  = 1;
    localparam int CMD_SUB  = 2;
    localparam int CMD_SBB  = 3;
    localparam int CMD_INC  = 4;
    localparam int CMD_DEC  = 5;
    localparam int CMD_AND  = 6;
    localparam int CMD_OR   = 7;
    localparam int CMD_XOR  = 8;
    localparam int CMD_NOT  = 9;
    localparam int CMD_CMP  = 10;
    localparam int CMD_CMPS = 11;
    localparam int CMD_MUL  = 12;
    localparam int CMD_DIV  = 13;

    // EFLAGS bit positions touched by the execute stage.
    localparam int EFLAGS_CF = 0;
    localparam int EFLAGS_PF = 2;
    localparam int EFLAGS_ZF = 6;
    localparam int EFLAGS_SF = 7;
    localparam int EFLAGS_OF = 11;

    // Operand size encodings; 3 behaves as 32-bit.
    localparam logic [1:0] OPSIZE_8  = 2'd0;
    localparam logic [1:0] OPSIZE_16 = 2'd1;
    localparam logic [1:0] OPSIZE_32 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALU,
        ST_ITER,
        ST_DONE
    } state_t;

    function automatic logic [N_W-1:0] size_bits(input logic [1:0] opsize);
        case (opsize)
            OPSIZE_8:  return N_W'(8);
            OPSIZE_16: return N_W'(16);
            default:   return N_W'(32);
        endcase
    endfunction

endpackage

// File: rtl/exec_muldiv_iter.sv
// rtl/exec_muldiv_iter.sv - iterative unsigned shift-add multiply / restoring divide, one bit per cycle
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load a, b, n and begin (a, b already masked to n bits)
//   is_div       1 = divide a/b, 0 = multiply a*b
//   n            operand width in bits (8/16/32)
//   a, b         multiplicand/multiplier or dividend/divisor
//   busy         iterations in progress
//   done         high during the final iteration cycle
//   lo, hi       value the result registers take at the end of this cycle:
//                product low/high (multiply) or quotient/remainder (divide);
//                final when done is high
module exec_muldiv_iter
    import exec_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [N_W-1:0]   n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic                 busy_q;
    logic                 div_q;
    logic [N_W-1:0]       n_q;
    logic [N_W-1:0]       cnt;
    logic [2*WIDTH-1:0]   acc;     // product, or remainder in the low WIDTH bits
    logic [WIDTH-1:0]     sh;      // multiplier / dividend, consumed MSB-first
    logic [WIDTH-1:0]     opa;     // multiplicand / divisor
    logic [WIDTH-1:0]     quo;

    logic [WIDTH-1:0]     top_m;
    logic                 msb;
    logic [2*WIDTH-1:0]   acc_mul;
    logic [WIDTH:0]       r2;
    logic                 ge;
    logic [WIDTH:0]       rem_nx;
    logic [WIDTH-1:0]     quo_nx;
    logic [2*WIDTH-1:0]   acc_nx;

    always_comb begin
        // Bit n-1 of sh is the next multiplier/dividend bit; sh shifts left each step.
        top_m   = {{(WIDTH-1){1'b0}}, 1'b1} << (n_q - N_W'(1));
        msb     = |(sh & top_m);
        acc_mul = (acc << 1) + {{WIDTH{1'b0}}, (msb ? opa : {WIDTH{1'b0}})};
        r2      = {acc[WIDTH-1:0], msb};
        ge      = (r2 >= {1'b0, opa});
        rem_nx  = ge ? (r2 - {1'b0, opa}) : r2;
        quo_nx  = {quo[WIDTH-2:0], ge};
        acc_nx  = div_q ? {{(WIDTH-1){1'b0}}, rem_nx} : acc_mul;
        lo      = div_q ? quo_nx : acc_mul[WIDTH-1:0];
        hi      = div_q ? rem_nx[WIDTH-1:0] : WIDTH'(acc_mul >> n_q);
    end

    assign busy = busy_q;
    assign done = busy_q & (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            n_q    <= N_W'(32);
            cnt    <= '0;
            acc    <= '0;
            sh     <= '0;
            opa    <= '0;
            quo    <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            div_q  <= is_div;
            n_q    <= n;
            cnt    <= n - N_W'(1);
            acc    <= '0;
            sh     <= is_div ? a : b;
            opa    <= is_div ? b : a;
            quo    <= '0;
        end else if (busy_q) begin
            acc <= acc_nx;
            sh  <= sh << 1;
            quo <= quo_nx;
            cnt <= cnt - N_W'(1);
            if (cnt == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_seq.sv
// rtl/exec_seq.sv - execute stage: handshake FSM, single-cycle ALU with EFLAGS, iterative MUL/DIV
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   command handshake from operand fetch
//   opc, opsize           command code and operand size (0=8b, 1=16b, 2/3=32b)
//   eflags_in             current EFLAGS
//   opnd0, opnd1          destination/first and source operands
//   out_valid / out_ready result handshake to writeback
//   result, result_hi     low result/quotient, MUL high half/DIV remainder
//   eflags_out            updated EFLAGS
//   wr_en                 result must be written back
//   div_fault             divide by zero
module exec_seq
    import exec_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] opc,
    input  logic [1:0]       opsize,
    input  logic [31:0]      eflags_in,
    input  logic [WIDTH-1:0] opnd0,
    input  logic [WIDTH-1:0] opnd1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [31:0]      eflags_out,
    output logic             wr_en,
    output logic             div_fault
);

    function automatic logic [WIDTH-1:0] width_mask(input logic [N_W-1:0] n);
        case (n)
            N_W'(8):  return WIDTH'(32'hFF);
            N_W'(16): return WIDTH'(32'hFFFF);
            default:  return WIDTH'(32'hFFFF_FFFF);
        endcase
    endfunction

    state_t             state;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic [31:0]        eflags_q;
    logic               wr_en_q;
    logic               div_fault_q;

    logic [OPC_W-1:0]   opc_q;
    logic [N_W-1:0]     n_q;
    logic [31:0]        flags_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    // Accept-side decode straight from the inputs.
    logic [N_W-1:0]     n_in;
    logic [WIDTH-1:0]   mask_in;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               accept;
    logic               in_is_div;
    logic               go_iter;

    assign n_in      = size_bits(opsize);
    assign mask_in   = width_mask(n_in);
    assign a_in      = opnd0 & mask_in;
    assign b_in      = opnd1 & mask_in;
    assign accept    = (state == ST_IDLE) & in_valid & in_ready_q;
    assign in_is_div = (int'(opc) == CMD_DIV);
    // Divide by zero never enters the engine; it faults from the ALU state.
    assign go_iter   = (int'(opc) == CMD_MUL) | (in_is_div & (b_in != '0));

    logic               iter_start;
    logic               iter_busy;
    logic               iter_done;
    logic [WIDTH-1:0]   iter_lo;
    logic [WIDTH-1:0]   iter_hi;

    assign iter_start = accept & go_iter & ~iter_busy;

    exec_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .is_div (in_is_div),
        .n      (n_in),
        .a      (a_in),
        .b      (b_in),
        .busy   (iter_busy),
        .done   (iter_done),
        .lo     (iter_lo),
        .hi     (iter_hi)
    );

    // Single-cycle ALU on the latched, masked operands.
    logic [WIDTH-1:0]   mask_q;
    logic [WIDTH-1:0]   msb_m;
    logic [WIDTH:0]     bit_n;
    logic [WIDTH-1:0]   op2;
    logic               cin;
    logic               arith;
    logic               is_sub;
    logic               keep_cf;
    logic               logic_op;
    logic [WIDTH:0]     sum;
    logic               carry;
    logic               cf_in;
    logic [WIDTH-1:0]   alu_res;
    logic [31:0]        alu_flags;
    logic               alu_wr;
    logic               alu_fault;
    logic [WIDTH-1:0]   mul_hi;
    logic [31:0]        iter_flags;

    assign mask_q = width_mask(n_q);
    assign msb_m  = mask_q ^ (mask_q >> 1);
    assign bit_n  = {1'b0, mask_q} + {{WIDTH{1'b0}}, 1'b1};
    assign cf_in  = flags_q[EFLAGS_CF];

    always_comb begin
        op2       = b_q;
        cin       = 1'b0;
        arith     = 1'b0;
        is_sub    = 1'b0;
        keep_cf   = 1'b0;
        logic_op  = 1'b0;
        alu_res   = '0;
        alu_flags = flags_q;
        alu_wr    = 1'b1;
        alu_fault = 1'b0;

        case (int'(opc_q))
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin
                arith = 1'b1;
                cin   = cf_in;
            end
            CMD_SUB, CMD_CMP, CMD_CMPS: begin
                arith  = 1'b1;
                is_sub = 1'b1;
                op2    = ~b_q & mask_q;
                cin    = 1'b1;
                alu_wr = (int'(opc_q) == CMD_SUB);
            end
            CMD_SBB: begin
                arith  = 1'b1;
                is_sub = 1'b1;
                op2    = ~b_q & mask_q;
                cin    = ~cf_in;
            end
            CMD_INC: begin
                arith   = 1'b1;
                keep_cf = 1'b1;
                op2     = {{(WIDTH-1){1'b0}}, 1'b1};
            end
            CMD_DEC: begin
                // a + all-ones == a - 1 in N bits
                arith   = 1'b1;
                keep_cf = 1'b1;
                op2     = mask_q;
            end
            CMD_AND: begin
                logic_op = 1'b1;
                alu_res  = a_q & b_q;
            end
            CMD_OR: begin
                logic_op = 1'b1;
                alu_res  = a_q | b_q;
            end
            CMD_XOR: begin
                logic_op = 1'b1;
                alu_res  = a_q ^ b_q;
            end
            CMD_NOT: alu_res = ~a_q & mask_q;
            CMD_DIV: begin
                // Only divide-by-zero reaches the ALU state.
                alu_wr    = 1'b0;
                alu_fault = 1'b1;
            end
            default: alu_wr = 1'b0;
        endcase

        sum   = {1'b0, a_q} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};
        carry = |(sum & bit_n);

        if (arith) begin
            alu_res = sum[WIDTH-1:0] & mask_q;
            alu_flags[EFLAGS_CF] = keep_cf ? cf_in : (carry ^ is_sub);
            // Overflow when both addends share a sign the result does not.
            alu_flags[EFLAGS_OF] = (|(a_q & msb_m) == |(op2 & msb_m)) &
                                   (|(alu_res & msb_m) != |(a_q & msb_m));
        end
        if (logic_op) begin
            alu_flags[EFLAGS_CF] = 1'b0;
            alu_flags[EFLAGS_OF] = 1'b0;
        end
        if (arith | logic_op) begin
            alu_flags[EFLAGS_ZF] = (alu_res == '0);
            alu_flags[EFLAGS_SF] = |(alu_res & msb_m);
            alu_flags[EFLAGS_PF] = ~^alu_res[7:0];
        end
    end

    always_comb begin
        mul_hi     = iter_hi & mask_q;
        iter_flags = flags_q;
        if (int'(opc_q) == CMD_MUL) begin
            iter_flags[EFLAGS_CF] = (mul_hi != '0);
            iter_flags[EFLAGS_OF] = (mul_hi != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            eflags_q    <= '0;
            wr_en_q     <= 1'b0;
            div_fault_q <= 1'b0;
            opc_q       <= '0;
            n_q         <= N_W'(32);
            flags_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        opc_q      <= opc;
                        n_q        <= n_in;
                        flags_q    <= eflags_in;
                        a_q        <= a_in;
                        b_q        <= b_in;
                        in_ready_q <= 1'b0;
                        state      <= go_iter ? ST_ITER : ST_ALU;
                    end
                end
                ST_ALU: begin
                    result_q    <= alu_res;
                    result_hi_q <= '0;
                    eflags_q    <= alu_flags;
                    wr_en_q     <= alu_wr;
                    div_fault_q <= alu_fault;
                    out_valid_q <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_ITER: begin
                    // Capture the engine's final-step values on its last cycle.
                    if (iter_done) begin
                        result_q    <= iter_lo & mask_q;
                        result_hi_q <= mul_hi;
                        eflags_q    <= iter_flags;
                        wr_en_q     <= 1'b1;
                        div_fault_q <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign result_hi  = result_hi_q;
    assign eflags_out = eflags_q;
    assign wr_en      = wr_en_q;
    assign div_fault  = div_fault_q;

endmodule

// File: tb/tb_exec_seq.sv
// tb/tb_exec_seq.sv - directed self-checking bench for exec_seq
module tb_exec_seq;
    import exec_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opc = '0;
    logic [1:0]  opsize = '0;
    logic [31:0] eflags_in = '0;
    logic [31:0] opnd0 = '0;
    logic [31:0] opnd1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic [31:0] eflags_out;
    logic        wr_en;
    logic        div_fault;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          op;
        logic [1:0]  sz;
        logic [31:0] fl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] efl;
        logic        wr;
    } vec_t;

    exec_seq #(.WIDTH(32), .OPC_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opc        (opc),
        .opsize     (opsize),
        .eflags_in  (eflags_in),
        .opnd0      (opnd0),
        .opnd1      (opnd1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_hi  (result_hi),
        .eflags_out (eflags_out),
        .wr_en      (wr_en),
        .div_fault  (div_fault)
    );

    always #5 clk = ~clk;

    // Present one command, accept it on the next edge, then count edges until out_valid.
    task automatic run_cmd(input int op, input logic [1:0] sz, input logic [31:0] fl,
                           input logic [31:0] a, input logic [31:0] b, output int lat);
        opc       = 6'(op);
        opsize    = sz;
        eflags_in = fl;
        opnd0     = a;
        opnd1     = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [99:0] obs;
        obs = {in_ready, out_valid, wr_en, div_fault, result, result_hi, eflags_out};
        checks++;
        if (obs !== {4'b1000, 96'h0}) begin
            failures++;
            $display("FAIL reset obs=%h exp=%h", obs, {4'b1000, 96'h0});
        end
    endtask

    task automatic test_add();
        int lat;
        logic [97:0] obs;
        run_cmd(CMD_ADD, 2'd2, 32'h0, 32'hFFFF_FFFF, 32'h1, lat);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL add_latency got=%0d exp=2", lat);
        end
        obs = {result_hi, result, eflags_out, wr_en, div_fault};
        checks++;
        if (obs !== {32'h0, 32'h0, 32'h45, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL add32 obs=%h exp=%h", obs, {32'h0, 32'h0, 32'h45, 1'b1, 1'b0});
        end
        handshake();
    endtask

    task automatic test_sub_cmp();
        int lat;
        logic [97:0] obs;
        logic [32:0] fo;
        run_cmd(CMD_SUB, 2'd0, 32'h0, 32'h80, 32'h01, lat);
        obs = {result_hi, result, eflags_out, wr_en, div_fault};
        checks++;
        if (obs !== {32'h0, 32'h7F, 32'h800, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sub8 obs=%h exp=%h", obs, {32'h0, 32'h7F, 32'h800, 1'b1, 1'b0});
        end
        handshake();
        run_cmd(CMD_CMP, 2'd0, 32'h0, 32'h80, 32'h01, lat);
        fo = {eflags_out, wr_en};
        checks++;
        if (fo !== {32'h800, 1'b0}) begin
            failures++;
            $display("FAIL cmp8 obs=%h exp=%h", fo, {32'h800, 1'b0});
        end
        handshake();
    endtask

    task automatic test_alu_table();
        vec_t tbl[9];
        int lat;
        logic [97:0] obs;
        logic [97:0] exp_v;
        tbl[0] = '{CMD_INC, 2'd0, 32'h1,   32'h7F,        32'h0,        32'h80,        32'h881, 1'b1};
        tbl[1] = '{CMD_XOR, 2'd1, 32'h801, 32'hFFFF,      32'h0F0F,     32'hF0F0,      32'h84,  1'b1};
        tbl[2] = '{CMD_NOT, 2'd1, 32'h8C5, 32'h00FF,      32'h1234,     32'hFF00,      32'h8C5, 1'b1};
        tbl[3] = '{CMD_ADD, 2'd0, 32'h0,   32'hABCD_12FF, 32'h1234_5601, 32'h0,        32'h45,  1'b1};
        tbl[4] = '{CMD_SBB, 2'd0, 32'h1,   32'h10,        32'h10,       32'hFF,        32'h85,  1'b1};
        tbl[5] = '{CMD_DEC, 2'd2, 32'h1,   32'h0,         32'h0,        32'hFFFF_FFFF, 32'h85,  1'b1};
        tbl[6] = '{63,      2'd2, 32'h123, 32'h5,         32'h6,        32'h0,         32'h123, 1'b0};
        tbl[7] = '{CMD_AND, 2'd2, 32'h801, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0,        32'h44,  1'b1};
        tbl[8] = '{CMD_OR,  2'd3, 32'h0,   32'h8000_0000, 32'h1,        32'h8000_0001, 32'h80,  1'b1};
        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].op, tbl[i].sz, tbl[i].fl, tbl[i].a, tbl[i].b, lat);
            checks++;
            if (lat !== 2) begin
                failures++;
                $display("FAIL alu_latency[%0d] got=%0d exp=2", i, lat);
            end
            obs   = {result_hi, result, eflags_out, wr_en, div_fault};
            exp_v = {32'h0, tbl[i].res, tbl[i].efl, tbl[i].wr, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL alu[%0d] obs=%h exp=%h", i, obs, exp_v);
            end
            handshake();
        end
    endtask

    task automatic test_mul();
        int lat;
        logic [97:0] obs;
        run_cmd(CMD_MUL, 2'd1, 32'h0, 32'h1234, 32'h0100, lat);
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL mul16_latency got=%0d exp=17", lat);
        end
        obs = {result_hi, result, eflags_out, wr_en, div_fault};
        checks++;
        if (obs !== {32'h12, 32'h3400, 32'h801, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL mul16 obs=%h exp=%h", obs, {32'h12, 32'h3400, 32'h801, 1'b1, 1'b0});
        end
        handshake();
        run_cmd(CMD_MUL, 2'd0, 32'h8C5, 32'h0F, 32'h11, lat);
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL mul8_latency got=%0d exp=9", lat);
        end
        obs = {result_hi, result, eflags_out, wr_en, div_fault};
        checks++;
        if (obs !== {32'h0, 32'hFF, 32'hC4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL mul8 obs=%h exp=%h", obs, {32'h0, 32'hFF, 32'hC4, 1'b1, 1'b0});
        end
        handshake();
    endtask

    task automatic test_div();
        int lat;
        logic [97:0] obs;
        run_cmd(CMD_DIV, 2'd2, 32'h202, 32'd100, 32'd7, lat);
        checks++;
        if (lat !== 33) begin
            failures++;
            $display("FAIL div32_latency got=%0d exp=33", lat);
        end
        obs = {result_hi, result, eflags_out, wr_en, div_fault};
        checks++;
        if (obs !== {32'd2, 32'd14, 32'h202, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL div32 obs=%h exp=%h", obs, {32'd2, 32'd14, 32'h202, 1'b1, 1'b0});
        end
        handshake();
        run_cmd(CMD_DIV, 2'd0, 32'h0, 32'h1FF, 32'h10, lat);
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL div8_latency got=%0d exp=9", lat);
        end
        obs = {result_hi, result, eflags_out, wr_en, div_fault};
        checks++;
        if (obs !== {32'hF, 32'hF, 32'h0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL div8 obs=%h exp=%h", obs, {32'hF, 32'hF, 32'h0, 1'b1, 1'b0});
        end
        handshake();
        run_cmd(CMD_DIV, 2'd2, 32'hACD, 32'd55, 32'd0, lat);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL div0_latency got=%0d exp=2", lat);
        end
        obs = {result_hi, result, eflags_out, wr_en, div_fault};
        checks++;
        if (obs !== {32'h0, 32'h0, 32'hACD, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL div0 obs=%h exp=%h", obs, {32'h0, 32'h0, 32'hACD, 1'b0, 1'b1});
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [65:0] obs;
        run_cmd(CMD_ADD, 2'd0, 32'h0, 32'd5, 32'd3, lat);
        // A second command is presented while the result is held.
        opc       = 6'(CMD_SUB);
        opsize    = 2'd2;
        opnd0     = 32'h1111;
        opnd1     = 32'h2222;
        eflags_in = 32'hFFF;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            obs = {out_valid, in_ready, result, eflags_out};
            checks++;
            if (obs !== {1'b1, 1'b0, 32'h8, 32'h0}) begin
                failures++;
                $display("FAIL hold[%0d] obs=%h exp=%h", c, obs, {1'b1, 1'b0, 32'h8, 32'h0});
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL release obs=%b exp=01", {out_valid, in_ready});
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL ignored_cmd obs=%b exp=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        int spurious;
        logic [97:0] obs;
        opc       = 6'(CMD_MUL);
        opsize    = 2'd2;
        eflags_in = 32'h0;
        opnd0     = 32'hFFFF_FFFF;
        opnd1     = 32'h3;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, wr_en, div_fault, result, result_hi, eflags_out} !== {4'b1000, 96'h0}) begin
            failures++;
            $display("FAIL mid_reset obs=%h exp=%h",
                     {in_ready, out_valid, wr_en, div_fault, result, result_hi, eflags_out}, {4'b1000, 96'h0});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            failures++;
            $display("FAIL post_reset_emit got=%0d exp=0", spurious);
        end
        run_cmd(CMD_ADC, 2'd0, 32'h1, 32'hFF, 32'h0, lat);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL adc_latency got=%0d exp=2", lat);
        end
        obs = {result_hi, result, eflags_out, wr_en, div_fault};
        checks++;
        if (obs !== {32'h0, 32'h0, 32'h45, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL adc8 obs=%h exp=%h", obs, {32'h0, 32'h0, 32'h45, 1'b1, 1'b0});
        end
        handshake();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_add();
        test_sub_cmp();
        test_alu_table();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_seq.md
Name: exec_seq

Overview:
Next-generation execute stage. Accepts one decoded command per handshake with operand size 8/16/32, and computes the result and arithmetic flags. ADD/ADC/INC/SUB/SBB/DEC/AND/OR/XOR/NOT/CMP/CMPS complete in one compute cycle. MUL/DIV run on an iterative multi-cycle engine. Sits between operand fetch and writeback, with valid/ready on both sides.

Parameters:
WIDTH, 32, maximum operand width in bits (must be ≥32 and a multiple of 8)
OPC_W, 6, command opcode width (matches generated command table)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  command presented
in_ready  output  1  block idle, can accept
opc  input  OPC_W  command code (generated CMD_* values)
opsize  input  2  0=8b, 1=16b, 2=32b; 3 treated as 32b
eflags_in  input  32  current EFLAGS
opnd0  input  WIDTH  destination/first operand
opnd1  input  WIDTH  source operand
out_valid  output  1  result held valid
out_ready  input  1  writeback accepts
result  output  WIDTH  low result / quotient
result_hi  output  WIDTH  MUL high half / DIV remainder, else 0
eflags_out  output  32  updated EFLAGS
wr_en  output  1  result must be written (0 for CMP/CMPS/fault)
div_fault  output  1  divide by zero

Behaviour:
- Decided: single clock clk; rst_n asynchronous assert, active-low. Reset forces IDLE, in_ready=1, out_valid=0, result=0, result_hi=0, eflags_out=0, wr_en=0, div_fault=0.
- Operand width N = 8/16/32 from opsize. All inputs are masked to N bits at accept. Outputs are zero-extended above N.
- FSM states: IDLE, ALU, ITER, DONE.
- IDLE: in_ready=1. in_valid&in_ready latches opc, opsize, eflags_in and operands.
  - Go to ITER for MUL/DIV with divisor≠0.
  - Otherwise go to ALU, which also covers DIV by zero.
- ALU (1 cycle): compute, register outputs, go to DONE. Accept-to-out_valid latency = 2 cycles.
- ITER: shift-add multiply or restoring divide, one bit per cycle, N iterations; counter counts N-1 down to 0. Then go to DONE. Latency = N+1 cycles.
- DONE: out_valid=1, outputs stable. out_valid&out_ready returns to IDLE. in_ready stays 0 until the cycle after the handshake, so there is no same-cycle re-accept.
- Arithmetic (N-bit):
  - ADD: a+b.
  - ADC: a+b+CF.
  - SUB/CMP/CMPS: a+~b+1.
  - SBB: a+~b+!CF.
  - INC/DEC: a±1 with CF preserved.
  - NOT: ~a, all flags preserved.
  - AND/OR/XOR: CF=OF=0.
- Flags updated (EFLAGS bits CF0 PF2 ZF6 SF7 OF11), taken from the N-bit result:
  - CF = carry-out for add, borrow for sub.
  - PF = even parity of the low 8 bits.
  - ZF = (result==0).
  - SF = result[N-1].
  - OF = signed overflow.
  - All other eflags bits pass through unchanged.
- MUL: unsigned, {result_hi,result} = a*b. CF=OF=(result_hi≠0). Other flags preserved.
- DIV: unsigned, result=a/b, result_hi=a%b, flags preserved.
  - b==0 → div_fault=1, wr_en=0, result=0, result_hi=0, eflags unchanged. No ITER.
- Unknown opc: wr_en=0, flags unchanged, result=0; completes via ALU.
- rst_n asserted mid-ITER or in DONE: operation is discarded, nothing is emitted after release.

Decomposition:
- Shared package: CMD_* codes from the generated command table, EFLAGS_* bit indices, opsize encodings, FSM state enum.
- One sub-module, exec_muldiv_iter:
  - Inputs: start, is_div, N, a, b.
  - Outputs: busy, done pulse, lo, hi.
  - Holds the counter and the partial/remainder registers.
- exec_seq holds the handshake FSM, the single-cycle ALU and flag logic.

Test Plan:
- ADD 32b, opnd0=0xFFFFFFFF, opnd1=1, eflags_in=0 → out_valid 2 cycles after accept; result=0, CF=1, ZF=1, PF=1, SF=0, OF=0; wr_en=1.
- SUB 8b, opnd0=0x80, opnd1=0x01 → result=0x7F, OF=1, CF=0, SF=0. Then CMP with the same operands → same flags, wr_en=0.
- MUL 16b, 0x1234*0x0100 → out_valid exactly 17 cycles after accept; result=0x3400, result_hi=0x0012, CF=OF=1.
- DIV 32b, 100/7 → result=14, result_hi=2, 33-cycle latency. DIV with opnd1=0 → div_fault=1, wr_en=0, 2-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, a new in_valid is ignored. Release → one handshake, in_ready=1 next cycle.
- Drop rst_n mid-MUL at iteration 5 → outputs zero immediately, IDLE. After release, ADC 8b 0xFF+0x00 with CF=1 → result=0x00, CF=1, ZF=1.
